// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
//   DEFAULT_WIDTH : default operand width
//   OP_*          : Op encodings (MULT, MULTU, DIV, DIVU)
//   state_e       : control FSM states
//   op_is_signed / op_is_div : Op decode helpers
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate (purely combinational).
//   neg     : 1 = output -in_val, 0 = pass through
//   in_val  : WIDTH-bit input
//   out_val : WIDTH-bit result
module muldiv_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] out_val
);

  assign out_val = neg ? (~in_val + WIDTH'(1)) : in_val;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes and fix the signs in a final cycle.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   Start, Op    : launch MULT/MULTU/DIV/DIVU (sampled only when idle)
//   A, B         : operands; A is also the MTHI/MTLO data source
//   WrHi, WrLo   : MTHI / MTLO write strobes (idle and Start=0 only)
//   Hi, Lo       : HI/LO registers
//   Busy         : operation in flight (RUN and FIX)
//   Done         : one-cycle pulse when Hi/Lo receive a new result
//   DivByZero    : last divide had B=0; cleared by the next accepted Start
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WrHi,
  input  logic             WrLo,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;   // product halves, or remainder / quotient
  logic [WIDTH-1:0] opb_q;                // multiplicand or divisor magnitude
  logic             is_div_q;
  logic             neg_quot_q, neg_rem_q;
  logic             b_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;

  logic             start_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0] quot_fixed, rem_fixed;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial, div_diff;
  logic [WIDTH-1:0] acc_hi_d, acc_lo_d;

  assign start_signed = op_is_signed(Op);

  muldiv_negate #(.WIDTH(WIDTH)) u_mag_a (
    .neg     (start_signed & A[WIDTH-1]),
    .in_val  (A),
    .out_val (mag_a)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_mag_b (
    .neg     (start_signed & B[WIDTH-1]),
    .in_val  (B),
    .out_val (mag_b)
  );

  muldiv_negate #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .neg     (neg_quot_q),
    .in_val  ({acc_hi_q, acc_lo_q}),
    .out_val (prod_fixed)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_fix_quot (
    .neg     (neg_quot_q),
    .in_val  (acc_lo_q),
    .out_val (quot_fixed)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .neg     (neg_rem_q),
    .in_val  (acc_hi_q),
    .out_val (rem_fixed)
  );

  // One iteration. Multiply: add multiplicand when the multiplier LSB (acc_lo[0]) is set,
  // then shift the whole accumulator right. Divide: shift the next dividend bit into the
  // partial remainder and keep the difference only when it did not go negative.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    if (is_div_q) begin
      // A restored remainder is always below the divisor, so WIDTH bits suffice.
      acc_hi_d = div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
      acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_hi_d = mul_sum[WIDTH:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (cnt_q == LastCnt) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= mag_a;
            opb_q      <= mag_b;
            is_div_q   <= op_is_div(Op);
            neg_quot_q <= start_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem_q  <= start_signed & A[WIDTH-1];
            b_zero_q   <= (B == '0);
            dbz_q      <= 1'b0;
          end else begin
            if (WrHi) hi_q <= A;
            if (WrLo) lo_q <= A;
          end
        end
        RUN: begin
          cnt_q    <= cnt_q + CntW'(1);
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div_q) begin
            // With B=0 the remainder path already re-forms A, only the quotient is forced.
            hi_q  <= rem_fixed;
            lo_q  <= b_zero_q ? '1 : quot_fixed;
            dbz_q <= b_zero_q;
          end else begin
            {hi_q, lo_q} <= prod_fixed;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers. It sits in the EX stage beside ALU32Bit and takes the same A/B operands from the ID/EX register. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Its Hi/Lo outputs feed the EX result mux for MFHI/MFLO, and its Busy output feeds the hazard unit, which stalls the pipeline.

## Interface
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- Clock and reset: one clock; reset is asynchronous and active-low.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  launches the operation selected by Op; sampled only when Busy=0.
- Op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  WIDTH  multiplicand / dividend; also the data source for MTHI/MTLO.
- B  in  WIDTH  multiplier / divisor.
- WrHi  in  1  MTHI: Hi <= A.
- WrLo  in  1  MTLO: Lo <= A.
- Hi  out  WIDTH  HI register: product upper half or remainder.
- Lo  out  WIDTH  LO register: product lower half or quotient.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse when Hi/Lo hold a new result.
- DivByZero  out  1  last DIV/DIVU had B=0; held until the next accepted Start.

## Operation
- **States**
  - IDLE: accepts Start or WrHi/WrLo.
  - RUN: WIDTH iterations, one bit per cycle.
  - FIX: sign correction, then Hi/Lo write.
- **IDLE, Start=1**
  - Latch |A|, |B| (signed ops) or A, B raw (unsigned ops).
  - Latch result signs: quotient/product sign = A[31]^B[31]; remainder sign = A[31]. Both are 0 for unsigned ops.
  - Clear iteration counter and DivByZero; go to RUN.
- **RUN, multiply:** shift-add on a 2*WIDTH accumulator.
- **RUN, divide:** restoring shift-subtract; the partial remainder is WIDTH+1 bits.
- **RUN exit:** after counter reaches WIDTH-1, go to FIX.
- **FIX**
  - Negate product / quotient / remainder as the latched signs require.
  - Write Hi/Lo; multiply writes {Hi,Lo} = 64-bit product.
  - Go to IDLE.
- **Divide by zero (B=0):** still runs the full latency. Result Lo=32'hFFFFFFFF, Hi=A (original, unsigned view); DivByZero=1.
- **Signed overflow:** DIV 32'h80000000 / 32'hFFFFFFFF gives Lo=32'h80000000, Hi=0, which is the natural result of magnitude arithmetic truncated to WIDTH. DivByZero stays 0.
- **Truncation:** remainder truncates toward zero; |Hi| < |B| and Hi takes A's sign.
- **WrHi/WrLo**
  - Honoured only in IDLE with Start=0.
  - Both asserted: both written.
  - Ignored while Busy, and ignored when Start is asserted in the same cycle.
- **Start while Busy:** ignored; the operation in flight is unaffected.
- **Reset**
  - Applies at any time, including mid-operation; aborts the operation.
  - Values: state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, counter=0.

## Timing
- Start sampled at edge k:
  - Busy=1 after edge k, through the FIX cycle (WIDTH+1 = 33 cycles).
  - Busy=0 after edge k+33.
  - Hi/Lo updated at edge k+33; Done=1 for exactly the cycle following edge k+33.
- Back-to-back: a new Start is accepted in the Done cycle, so the issue interval is 34 cycles.
- MTHI/MTLO: Hi/Lo reflect A one edge after WrHi/WrLo; Done is not asserted.
- Hi/Lo are registered outputs and are stable while Busy, including old values during RUN. Intermediate results never appear on Hi/Lo.
- Busy is registered (no combinational path from Start).
- DivByZero clears one edge after an accepted Start and becomes valid together with Done.

## Structure
- Shared package muldiv_pkg:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State enum: IDLE, RUN, FIX.
  - WIDTH default.
- One sub-module is natural: muldiv_negate. It is a combinational conditional two's-complement negate, parameterised by width, used for operand magnitude and FIX sign correction.
- Everything else lives in muldiv_unit: FSM, counter, accumulator/remainder registers, HI/LO.

## Test plan
- MULT A=10, B=5 -> after 33 Busy cycles: Lo=32'h00000032, Hi=0, Done pulse of exactly one cycle.
- MULT A=32'hFFFFFFFF, B=2 -> Hi=32'hFFFFFFFF, Lo=32'hFFFFFFFE. MULTU A=B=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001.
- Signed divide:
  - DIV A=-7 (32'hFFFFFFF9), B=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
  - DIV 32'h80000000 / 32'hFFFFFFFF -> Lo=32'h80000000, Hi=0, DivByZero=0.
- Divide by zero: DIVU A=32'h12345678, B=0 -> Lo=32'hFFFFFFFF, Hi=32'h12345678, DivByZero=1. The next MULT clears DivByZero one edge after its Start.
- Start with new operands at cycles 5 and 20 during an operation -> both ignored, the original result is written at edge k+33. In the same run, WrHi with A=32'hDEAD0000 while Busy -> ignored; after Done, WrHi with A=32'hDEAD0000 -> Hi=32'hDEAD0000 next edge.
- Reset_n low at RUN cycle 16 -> asynchronously Busy=0, Hi=Lo=0, Done=0. After release, MULT 3*4 -> Lo=12 at the normal 33-cycle latency.
